// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 target emulating a 25xx-style serial EEPROM (READ/WRITE/WREN/WRDI/RDSR).
// SPI pins are oversampled on clk; a parallel preload port initialises the byte array.
module spi_eeprom_responder #(
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              copi,
    output logic              cipo,
    output logic              cipo_oe,
    output logic              wel,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_H, ADDR_L, RD_DATA, WR_DATA, STATUS, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, copi_sync_q;
    logic                   sck_prev_q, csn_prev_q;
    logic                   sck_s, csn_s, copi_s;
    logic                   sck_rise, sck_fall, csn_fall;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [6:0]        sr_in_q, sr_in_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        out_sr_q, out_sr_d;
    logic              cipo_q, cipo_d;
    logic              oe_q, oe_d;
    logic              wel_q, wel_d;
    logic              wr_txn_q, wr_txn_d;

    logic [7:0]        mem_q [DEPTH];
    logic              mem_we;
    logic [7:0]        rx_byte;
    logic [7:0]        status_byte;
    logic [ADDR_W-1:0] addr_shift, addr_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            copi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], cs_n};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            sck_prev_q  <= sck_s;
            csn_prev_q  <= csn_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign csn_s    = csn_sync_q[SYNC_STAGES-1];
    assign copi_s   = copi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign csn_fall = ~csn_s & csn_prev_q;

    // Address bits are shifted straight into the ADDR_W-wide register, so after
    // 16 rises only the low ADDR_W bits of the big-endian address remain.
    assign rx_byte     = {sr_in_q, copi_s};
    assign addr_shift  = {addr_q[ADDR_W-2:0], copi_s};
    assign addr_inc    = addr_q + ADDR_W'(1);
    assign status_byte = {6'b0, wel_q, 1'b0};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_in_d  = sr_in_q;
        addr_d   = addr_q;
        out_sr_d = out_sr_q;
        cipo_d   = cipo_q;
        oe_d     = oe_q;
        wel_d    = wel_q;
        wr_txn_d = wr_txn_q;
        mem_we   = 1'b0;

        if (csn_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            cipo_d  = 1'b0;
            if (wr_txn_q) begin
                wel_d    = 1'b0;
                wr_txn_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (csn_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        sr_in_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            case (rx_byte)
                                8'h03: state_d = ADDR_H;
                                8'h02: begin
                                    state_d  = ADDR_H;
                                    wr_txn_d = 1'b1;
                                end
                                8'h06: begin
                                    wel_d   = 1'b1;
                                    state_d = IGNORE;
                                end
                                8'h04: begin
                                    wel_d   = 1'b0;
                                    state_d = IGNORE;
                                end
                                8'h05: begin
                                    state_d  = STATUS;
                                    out_sr_d = status_byte;
                                    oe_d     = 1'b1;
                                end
                                default: state_d = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR_H: begin
                    if (sck_rise) begin
                        addr_d = addr_shift;
                        cnt_d  = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_d = ADDR_L;
                    end
                end
                ADDR_L: begin
                    if (sck_rise) begin
                        addr_d = addr_shift;
                        cnt_d  = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (wr_txn_q) begin
                                state_d = WR_DATA;
                            end else begin
                                state_d  = RD_DATA;
                                out_sr_d = mem_q[addr_shift];
                                oe_d     = 1'b1;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (sck_fall) begin
                        cipo_d   = out_sr_q[7];
                        out_sr_d = {out_sr_q[6:0], 1'b0};
                        cnt_d    = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            addr_d   = addr_inc;
                            out_sr_d = mem_q[addr_inc];
                        end
                    end
                end
                WR_DATA: begin
                    if (sck_rise) begin
                        sr_in_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            mem_we = wel_q;
                            addr_d = addr_inc;
                        end
                    end
                end
                STATUS: begin
                    if (sck_fall) begin
                        cipo_d   = out_sr_q[7];
                        out_sr_d = {out_sr_q[6:0], 1'b0};
                        cnt_d    = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) out_sr_d = status_byte;
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sr_in_q  <= '0;
            addr_q   <= '0;
            out_sr_q <= '0;
            cipo_q   <= 1'b0;
            oe_q     <= 1'b0;
            wel_q    <= 1'b0;
            wr_txn_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_in_q  <= sr_in_d;
            addr_q   <= addr_d;
            out_sr_q <= out_sr_d;
            cipo_q   <= cipo_d;
            oe_q     <= oe_d;
            wel_q    <= wel_d;
            wr_txn_q <= wr_txn_d;
        end
    end

    // The SPI write is issued after the preload so it wins on an address clash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (load_en) mem_q[load_addr] <= load_data;
            if (mem_we)  mem_q[addr_q]    <= rx_byte;
        end
    end

    assign cipo    = cipo_q;
    assign cipo_oe = oe_q;
    assign wel     = wel_q;

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Self-checking bench for spi_eeprom_responder: directed EEPROM scenarios plus
// randomized preload/write/read traffic checked against a byte-array model.
module tb_spi_eeprom_responder;

    localparam int ADDR_W = 6;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int HALF   = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sck = 1'b0;
    logic              cs_n = 1'b1;
    logic              copi = 1'b0;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [7:0]        load_data = '0;
    logic              cipo, cipo_oe, wel;

    spi_eeprom_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck       (sck),
        .cs_n      (cs_n),
        .copi      (copi),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .wel       (wel),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] model_mem [DEPTH];
    logic       model_wel = 1'b0;
    logic [7:0] tx_buf [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int a, input logic [7:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = ADDR_W'(a);
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
        model_mem[a % DEPTH] = d;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Sends nbits of v MSB-first; cipo is sampled just before each sck rise.
    task automatic spi_bits(input logic [7:0] v, input int nbits,
                            output logic [7:0] rx, output logic oe);
        rx = '0;
        oe = 1'b0;
        for (int k = 7; k > 7 - nbits; k--) begin
            copi = v[k];
            repeat (HALF) @(negedge clk);
            rx[k] = cipo;
            oe    = cipo_oe;
            sck   = 1'b1;
            repeat (HALF) @(negedge clk);
            sck   = 1'b0;
        end
    endtask

    // One full transaction of tx_buf[0..n-1]; expected response comes from the
    // model before the transfer, model state is updated after cs_n rises.
    task automatic run_xfer(input string tag, input int n);
        logic [7:0]  cmd;
        logic [15:0] a;
        logic [7:0]  exp_rx [16];
        logic        exp_oe [16];
        logic [7:0]  rx;
        logic        oe;
        cmd = tx_buf[0];
        a   = {tx_buf[1], tx_buf[2]};
        for (int i = 0; i < n; i++) begin
            exp_rx[i] = 8'h00;
            exp_oe[i] = 1'b0;
            if (cmd == 8'h03 && i >= 3) begin
                exp_rx[i] = model_mem[(int'(a) + i - 3) % DEPTH];
                exp_oe[i] = 1'b1;
            end
            if (cmd == 8'h05 && i >= 1) begin
                exp_rx[i] = {6'b0, model_wel, 1'b0};
                exp_oe[i] = 1'b1;
            end
        end
        cs_low();
        for (int i = 0; i < n; i++) begin
            spi_bits(tx_buf[i], 8, rx, oe);
            check($sformatf("%s_rx%0d", tag, i), 32'(rx), 32'(exp_rx[i]));
            check($sformatf("%s_oe%0d", tag, i), 32'(oe), 32'(exp_oe[i]));
        end
        cs_high();
        case (cmd)
            8'h06: model_wel = 1'b1;
            8'h04: model_wel = 1'b0;
            8'h02: begin
                for (int i = 3; i < n; i++)
                    if (model_wel) model_mem[(int'(a) + i - 3) % DEPTH] = tx_buf[i];
                model_wel = 1'b0;
            end
            default: ;
        endcase
        check($sformatf("%s_wel", tag), 32'(wel), 32'(model_wel));
        check($sformatf("%s_idle_oe", tag), 32'(cipo_oe), 32'd0);
    endtask

    task automatic do_cmd(input string tag, input logic [7:0] c);
        tx_buf[0] = c;
        run_xfer(tag, 1);
    endtask

    task automatic do_read(input string tag, input logic [15:0] a, input int nbytes);
        tx_buf[0] = 8'h03;
        tx_buf[1] = a[15:8];
        tx_buf[2] = a[7:0];
        for (int i = 0; i < nbytes; i++) tx_buf[3 + i] = 8'($urandom);
        run_xfer(tag, 3 + nbytes);
    endtask

    task automatic do_status(input string tag, input int nbytes);
        tx_buf[0] = 8'h05;
        for (int i = 0; i < nbytes; i++) tx_buf[1 + i] = 8'($urandom);
        run_xfer(tag, 1 + nbytes);
    endtask

    initial begin
        logic [7:0]  rx;
        logic        oe;
        logic [15:0] ra;
        int          len;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_cipo", 32'(cipo), 32'd0);
        check("rst_oe", 32'(cipo_oe), 32'd0);
        check("rst_wel", 32'(wel), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        preload(5, 8'hA5);
        preload(6, 8'h3C);
        do_read("rd5", 16'h0005, 2);

        preload(63, 8'h11);
        preload(0, 8'h22);
        do_read("rdwrap", 16'h003F, 2);
        do_read("rdhigh", 16'hFF3F, 1);

        tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h10; tx_buf[3] = 8'h55;
        run_xfer("wr_nowel", 4);
        do_read("rd10_a", 16'h0010, 1);

        do_cmd("wren1", 8'h06);
        tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h10;
        tx_buf[3] = 8'h55; tx_buf[4] = 8'h66;
        run_xfer("wr_wel", 5);
        do_read("rd10_b", 16'h0010, 2);

        do_cmd("wren2", 8'h06);
        do_status("st_on", 3);
        do_cmd("wrdi", 8'h04);
        do_status("st_off", 2);

        // Abort a read after four data bits.
        cs_low();
        spi_bits(8'h03, 8, rx, oe);
        spi_bits(8'h00, 8, rx, oe);
        spi_bits(8'h05, 8, rx, oe);
        spi_bits(8'h00, 4, rx, oe);
        check("abort_oe_before", 32'(oe), 32'd1);
        check("abort_bits", 32'(rx[7:4]), 32'(model_mem[5][7:4]));
        cs_n = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        check("abort_oe_after", 32'(cipo_oe), 32'd0);
        check("abort_cipo_after", 32'(cipo), 32'd0);
        repeat (2 * HALF) @(negedge clk);
        do_read("rd6_after_abort", 16'h0006, 1);

        do_cmd("wren3", 8'h06);
        tx_buf[0] = 8'h9F; tx_buf[1] = 8'h12; tx_buf[2] = 8'h34;
        run_xfer("unknown", 3);
        do_read("rd_after_unknown", 16'h0004, 4);
        do_cmd("wrdi2", 8'h04);

        for (int it = 0; it < 6; it++) begin
            preload($urandom_range(0, DEPTH - 1), 8'($urandom));
            preload($urandom_range(0, DEPTH - 1), 8'($urandom));
            do_cmd($sformatf("r%0d_en", it), ($urandom_range(0, 3) != 0) ? 8'h06 : 8'h04);
            ra  = 16'($urandom_range(0, 65535));
            len = $urandom_range(1, 3);
            tx_buf[0] = 8'h02; tx_buf[1] = ra[15:8]; tx_buf[2] = ra[7:0];
            for (int i = 0; i < len; i++) tx_buf[3 + i] = 8'($urandom);
            run_xfer($sformatf("r%0d_wr", it), 3 + len);
            do_read($sformatf("r%0d_rd", it), ra, 4);
            do_status($sformatf("r%0d_st", it), 1);
        end

        // Asynchronous reset in the middle of a read data byte.
        do_cmd("wren4", 8'h06);
        preload(9, 8'hFF);
        cs_low();
        spi_bits(8'h03, 8, rx, oe);
        spi_bits(8'h00, 8, rx, oe);
        spi_bits(8'h09, 8, rx, oe);
        spi_bits(8'h00, 3, rx, oe);
        check("mid_oe", 32'(cipo_oe), 32'd1);
        check("mid_wel", 32'(wel), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cipo", 32'(cipo), 32'd0);
        check("arst_oe", 32'(cipo_oe), 32'd0);
        check("arst_wel", 32'(wel), 32'd0);
        sck  = 1'b0;
        cs_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        model_wel = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        do_read("rd_after_rst", 16'h0005, 2);
        do_read("rd9_after_rst", 16'h0009, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
